cpu_trace_checker: RTL and testbench

//   Synthesizable self-checking monitor that sits beside the single-cycle cpu and consumes its observation

---
 rtl/cpu_trace_checker.sv | 95 +++++++++
 tb/tb_cpu_trace_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker: table-driven per-instruction verdict monitor for the cpu; define CPU_TRACE_MASK_EN for a per-entry compare mask
module cpu_trace_checker #(
  parameter int NUM_CHECKS = 28,
  parameter int IDX_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_step,
  input  logic [DATA_W-1:0] datamem_readData,
  input  logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] addALUres,
  input  logic [DATA_W-1:0] reg_readData1,
  input  logic [DATA_W-1:0] reg_readData2,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_addr,
  input  logic [2:0]        tbl_sel,
  input  logic [DATA_W-1:0] tbl_value,
`ifdef CPU_TRACE_MASK_EN
  input  logic [DATA_W-1:0] tbl_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              passed,
  output logic [IDX_W:0]    fail_count,
  output logic [IDX_W-1:0]  first_fail_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEPTH = 1 << IDX_W;
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [2:0] sel_mem [DEPTH];
  logic [DATA_W-1:0] val_mem [DEPTH];
`ifdef CPU_TRACE_MASK_EN
  logic [DATA_W-1:0] mask_mem [DEPTH];
`endif
  logic [2:0] cur_sel;
  logic [DATA_W-1:0] obs;
  logic [DATA_W-1:0] diff;
  logic mismatch;
  always_ff @(posedge clk)
    if (tbl_we && state != RUN) begin
      sel_mem[tbl_addr] <= tbl_sel;
      val_mem[tbl_addr] <= tbl_value;
`ifdef CPU_TRACE_MASK_EN
      mask_mem[tbl_addr] <= tbl_mask;
`endif
    end
  always_comb begin
    cur_sel = sel_mem[idx];
    obs = cur_sel == 3'd0 ? datamem_readData :
          cur_sel == 3'd1 ? writeData :
          cur_sel == 3'd2 ? addALUres :
          cur_sel == 3'd3 ? reg_readData1 :
          cur_sel == 3'd4 ? reg_readData2 : ALUresult;
`ifdef CPU_TRACE_MASK_EN
    diff = (obs ^ val_mem[idx]) & mask_mem[idx];
`else
    diff = obs ^ val_mem[idx];
`endif
    mismatch = cur_sel < 3'd6 && diff != '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      passed <= 1'b0;
      fail_count <= '0;
      first_fail_idx <= '0;
      idx <= '0;
    end else if (state != RUN && start) begin
      state <= RUN;
      busy <= 1'b1;
      done <= 1'b0;
      passed <= 1'b0;
      fail_count <= '0;
      first_fail_idx <= '0;
      idx <= '0;
    end else if (state == RUN && cpu_step) begin
      if (mismatch) begin
        fail_count <= &fail_count ? fail_count : fail_count + 1'b1;
        if (fail_count == '0) first_fail_idx <= idx;
      end
      idx <= idx + 1'b1;
      if (idx == IDX_W'(NUM_CHECKS - 1)) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        passed <= fail_count == '0 && !mismatch;
      end
    end
endmodule

// File: tb/tb_cpu_trace_checker.sv
// tb_cpu_trace_checker: directed scoreboard bench for cpu_trace_checker
module tb_cpu_trace_checker;
  localparam int N = 28;
  typedef struct packed {logic [5:0] fc; logic [4:0] ffi; logic dn;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_step = 1'b0;
  logic tbl_we = 1'b0;
  logic [31:0] dm = '0, wd = '0, aa = '0, r1 = '0, r2 = '0, alu = '0;
  logic [4:0] tbl_addr = '0;
  logic [2:0] tbl_sel = '0;
  logic [31:0] tbl_value = '0;
`ifdef CPU_TRACE_MASK_EN
  logic [31:0] tbl_mask = '1;
`endif
  logic busy, done, passed;
  logic [5:0] fail_count;
  logic [4:0] first_fail_idx;
  logic [2:0] m_sel [N];
  logic [31:0] m_val [N];
  logic [31:0] m_mask [N];
  logic [5:0] e_fc;
  logic [4:0] e_ffi;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  cpu_trace_checker dut (
    .clk(clk), .reset(reset), .start(start), .cpu_step(cpu_step),
    .datamem_readData(dm), .writeData(wd), .addALUres(aa),
    .reg_readData1(r1), .reg_readData2(r2), .ALUresult(alu),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_sel(tbl_sel), .tbl_value(tbl_value),
`ifdef CPU_TRACE_MASK_EN
    .tbl_mask(tbl_mask),
`endif
    .busy(busy), .done(done), .passed(passed),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs_of(int k, int s);
    if (k == 6 && s == 3) return 32'h0;
    if (k == 10 && s == 5) return 32'h00003ffc;
    return 32'((k << 8) | (s << 4) | 1);
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic load(int a, logic [2:0] s, logic [31:0] v, logic [31:0] m);
    m_sel[a] = s;
    m_val[a] = v;
    m_mask[a] = m;
    @(negedge clk);
    tbl_we = 1'b1;
    tbl_addr = a[4:0];
    tbl_sel = s;
    tbl_value = v;
`ifdef CPU_TRACE_MASK_EN
    tbl_mask = m;
`endif
    @(posedge clk);
    #1 tbl_we = 1'b0;
  endtask

  task automatic load_base();
    for (int k = 0; k < N; k++) begin
      logic [2:0] s;
      s = k == 6 ? 3'd3 : 3'(k % 8);
      load(k, s, obs_of(k, s), '1);
    end
  endtask

  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e_fc = '0;
    e_ffi = '0;
    chk("start_busy", busy, 1);
    chk("start_fc", fail_count, 0);
  endtask

  task automatic step(int k);
    logic mm;
    exp_t e;
    @(negedge clk);
    dm = obs_of(k, 0);
    wd = obs_of(k, 1);
    aa = obs_of(k, 2);
    r1 = obs_of(k, 3);
    r2 = obs_of(k, 4);
    alu = obs_of(k, 5);
    cpu_step = 1'b1;
    mm = m_sel[k] < 3'd6 && ((obs_of(k, int'(m_sel[k])) ^ m_val[k]) & m_mask[k]) != '0;
    if (mm) begin
      if (e_fc == '0) e_ffi = k[4:0];
      if (e_fc != 6'h3f) e_fc++;
    end
    sb.push_back('{e_fc, e_ffi, k == N - 1});
    @(posedge clk);
    #1 cpu_step = 1'b0;
    e = sb.pop_front();
    chk($sformatf("fc@%0d", k), fail_count, e.fc);
    chk($sformatf("ffi@%0d", k), first_fail_idx, e.ffi);
    chk($sformatf("done@%0d", k), done, e.dn);
  endtask

  task automatic steps(int a, int b);
    for (int k = a; k <= b; k++) step(k);
  endtask

  task automatic run_all();
    run_start();
    steps(0, N - 1);
  endtask

  task automatic finish_run(logic p);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_passed", passed, p);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_passed", passed, 0);
    chk("rst_fc", fail_count, 0);
    chk("rst_ffi", first_fail_idx, 0);
    @(negedge clk) reset = 1'b0;
    load_base();
    run_all();
    finish_run(1);
    chk("t1_fc", fail_count, 0);

    load(6, 3, 32'h4, '1);
    run_all();
    finish_run(0);
    chk("t2_fc", fail_count, 1);
    chk("t2_ffi", first_fail_idx, 6);
    @(negedge clk) cpu_step = 1'b1;
    @(posedge clk);
    #1 cpu_step = 1'b0;
    chk("t2_extra_done", done, 1);
    chk("t2_extra_fc", fail_count, 1);
    load(6, 3, 32'h0, '1);

    load(2, 2, obs_of(2, 2) ^ 32'h1, '1);
    load(9, 1, obs_of(9, 1) ^ 32'h80, '1);
    load(7, 7, 32'hffffffff, '1);
    run_all();
    finish_run(0);
    chk("t3_fc", fail_count, 2);
    chk("t3_ffi", first_fail_idx, 2);
    load(2, 2, obs_of(2, 2), '1);
    load(9, 1, obs_of(9, 1), '1);

    run_start();
    steps(0, 9);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = c == 0;
      tbl_we = 1'b1;
      tbl_addr = 5'd12;
      tbl_sel = 3'd0;
      tbl_value = 32'hbad0bad0;
      @(posedge clk);
      #1 start = 1'b0;
      tbl_we = 1'b0;
      chk($sformatf("t4_busy@%0d", c), busy, 1);
      chk($sformatf("t4_done@%0d", c), done, 0);
    end
    steps(10, N - 1);
    finish_run(1);

    load(3, 3, 32'h12345678, '1);
    run_start();
    steps(0, 13);
    chk("t5_pre_fc", fail_count, 1);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_fc", fail_count, 0);
    chk("t5_ffi", first_fail_idx, 0);
    @(negedge clk) reset = 1'b0;
    load(3, 3, obs_of(3, 3), '1);
    run_all();
    finish_run(1);

    @(negedge clk);
    m_sel[0] = 3'd0;
    m_val[0] = obs_of(0, 0) ^ 32'h10;
    tbl_we = 1'b1;
    tbl_addr = 5'd0;
    tbl_sel = 3'd0;
    tbl_value = m_val[0];
    start = 1'b1;
    @(posedge clk);
    #1 tbl_we = 1'b0;
    start = 1'b0;
    e_fc = '0;
    e_ffi = '0;
    steps(0, N - 1);
    finish_run(0);
    chk("t7_fc", fail_count, 1);
    chk("t7_ffi", first_fail_idx, 0);
    load(0, 0, obs_of(0, 0), '1);

`ifdef CPU_TRACE_MASK_EN
    load(10, 5, 32'hdead3ffc, 32'h0000ffff);
    run_all();
    finish_run(1);
    load(10, 5, 32'hdead3ffc, '1);
    run_all();
    finish_run(0);
    chk("t6_fc", fail_count, 1);
    chk("t6_ffi", first_fail_idx, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
